// File: rtl/vrgather_seq.sv
// vrgather_seq: sequential vector register gather, vd[i] = vs2[vs1[i]].
// Processes LANES elements per RUN cycle and zeroes tail elements.
// An index at or beyond the element count selects zero.
// Optional feature macro: VRGATHER_MASK_EN adds the vm and vd_old inputs.
// Inactive (vm=0) active elements then take their value from vd_old.
module vrgather_seq #(
  parameter int unsigned VLEN_BITS = 128,
  parameter int unsigned LMUL      = 4,
  parameter int unsigned LANES     = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [1:0]                          sew,
  input  logic [$clog2(VLEN_BITS*LMUL/8):0]   vl,
  input  logic [VLEN_BITS*LMUL-1:0]           vs2_bus,
  input  logic [VLEN_BITS*LMUL-1:0]           vs1_bus,
`ifdef VRGATHER_MASK_EN
  input  logic [VLEN_BITS*LMUL/8-1:0]         vm,
  input  logic [VLEN_BITS*LMUL-1:0]           vd_old,
`endif
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [VLEN_BITS*LMUL-1:0]           vd_bus,
  output logic                                err
);

  localparam int unsigned W    = VLEN_BITS * LMUL;
  localparam int unsigned VLW  = $clog2(W / 8) + 1;
  localparam int unsigned M8   = W / 8;
  localparam int unsigned M16  = W / 16;
  localparam int unsigned M32  = W / 32;
  localparam int unsigned IW8  = $clog2(M8);
  localparam int unsigned IW16 = $clog2(M16);
  localparam int unsigned IW32 = $clog2(M32);
  localparam int unsigned SW   = $clog2(W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [1:0]       sew_q;
  logic [VLW-1:0]   e_q, base, m_in, e_in;
  logic [W-1:0]     vs2_q, vs1_q, vd_q, vd_n;
  logic             err_q;
`ifdef VRGATHER_MASK_EN
  logic [W/8-1:0]   vm_q;
  logic [W-1:0]     vd_old_q;
`endif

  logic [VLW-1:0]   i;
  logic [31:0]      idx, val;
  logic [SW-1:0]    pos;

  // Effective element count of the incoming operand set: min(vl, W/SEW).
  always_comb begin
    m_in = '0;
    case (sew)
      2'b00:   m_in = VLW'(M8);
      2'b01:   m_in = VLW'(M16);
      2'b10:   m_in = VLW'(M32);
      default: m_in = '0;
    endcase
    e_in = (vl < m_in) ? vl : m_in;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = (e_in == '0) ? DONE : RUN;
      end
      RUN: begin
        if ((base + VLW'(LANES)) >= e_q) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Gather one group of LANES elements starting at base; indices are range
  // tested at 32 bits after zero-extension so no high index bits are lost.
  always_comb begin
    vd_n = vd_q;
    i    = '0;
    idx  = '0;
    val  = '0;
    pos  = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      i   = base + VLW'(l);
      idx = '0;
      val = '0;
      pos = '0;
      if (i < e_q) begin
        case (sew_q)
          2'b00: begin
            pos = {i[IW8-1:0], 3'b000};
            idx = 32'(vs1_q[pos +: 8]);
            if (idx < 32'(M8)) val = 32'(vs2_q[{idx[IW8-1:0], 3'b000} +: 8]);
`ifdef VRGATHER_MASK_EN
            if (!vm_q[i[IW8-1:0]]) val = 32'(vd_old_q[pos +: 8]);
`endif
            vd_n[pos +: 8] = val[7:0];
          end
          2'b01: begin
            pos = {i[IW16-1:0], 4'b0000};
            idx = 32'(vs1_q[pos +: 16]);
            if (idx < 32'(M16)) val = 32'(vs2_q[{idx[IW16-1:0], 4'b0000} +: 16]);
`ifdef VRGATHER_MASK_EN
            if (!vm_q[i[IW8-1:0]]) val = 32'(vd_old_q[pos +: 16]);
`endif
            vd_n[pos +: 16] = val[15:0];
          end
          2'b10: begin
            pos = {i[IW32-1:0], 5'b00000};
            idx = vs1_q[pos +: 32];
            if (idx < 32'(M32)) val = vs2_q[{idx[IW32-1:0], 5'b00000} +: 32];
`ifdef VRGATHER_MASK_EN
            if (!vm_q[i[IW8-1:0]]) val = vd_old_q[pos +: 32];
`endif
            vd_n[pos +: 32] = val;
          end
          default: ;
        endcase
      end
    end
  end

  // Operand capture on accept, result accumulation while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sew_q    <= '0;
      e_q      <= '0;
      base     <= '0;
      vs2_q    <= '0;
      vs1_q    <= '0;
      vd_q     <= '0;
      err_q    <= 1'b0;
`ifdef VRGATHER_MASK_EN
      vm_q     <= '0;
      vd_old_q <= '0;
`endif
    end else if (state == IDLE && in_valid) begin
      sew_q    <= sew;
      e_q      <= e_in;
      base     <= '0;
      vs2_q    <= vs2_bus;
      vs1_q    <= vs1_bus;
      vd_q     <= '0;
      err_q    <= (sew == 2'b11);
`ifdef VRGATHER_MASK_EN
      vm_q     <= vm;
      vd_old_q <= vd_old;
`endif
    end else if (state == RUN) begin
      vd_q <= vd_n;
      base <= base + VLW'(LANES);
    end
  end

  // Result is only visible while presented, so partial sums never leak out.
  assign vd_bus = (state == DONE) ? vd_q : '0;
  assign err    = (state == DONE) ? err_q : 1'b0;

endmodule

// File: doc/vrgather_seq.md
VRGATHER_SEQ -- requirements
Module: vrgather_seq

Interface
REQ-001 SHALL have parameter VLEN_BITS, default 128: bits per vector register.
REQ-002 SHALL have parameter LMUL, default 4: registers per group; bus width W = VLEN_BITS*LMUL.
REQ-003 SHALL have parameter LANES, default 8: elements gathered per RUN cycle; power of two, 1..W/32.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1: operand set valid.
REQ-007 SHALL have port in_ready, output, 1: unit can accept operands.
REQ-008 SHALL have port sew, input, 2: 00=8b, 01=16b, 10=32b, 11=reserved.
REQ-009 SHALL have port vl, input, $clog2(W/8)+1: active element count.
REQ-010 SHALL have ports vs2_bus (source) and vs1_bus (indices), input, W each.
REQ-011 SHALL have port out_valid, output, 1: result valid.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-013 SHALL have port vd_bus, output, W: gathered result.
REQ-014 SHALL have port err, output, 1: reserved sew seen; valid with out_valid.

Function
REQ-015 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; in_ready=1 only in IDLE.
REQ-016 SHALL register sew, vl, vs2_bus, vs1_bus on in_valid&&in_ready; later input changes have no effect.
REQ-017 SHALL use M = W/SEW elements and effective count E = min(vl, M).
REQ-018 SHALL, per element i<E, set vd[i] = vs2[idx] if idx<M, else 0; idx = vs1[i] zero-extended to full SEW width.
REQ-019 SHALL set elements i>=E to 0 (tail zeroing).
REQ-020 SHALL process elements LANES at a time in ascending order; RUN lasts ceil(E/LANES) cycles.
REQ-021 SHALL go IDLE -> DONE directly (one cycle) when E=0 or sew=11; sew=11 gives vd_bus=0, err=1.
REQ-022 SHALL assert out_valid in DONE and hold vd_bus, err stable until out_valid&&out_ready.
REQ-023 SHALL return to IDLE on the handshake cycle; in_ready rises the following cycle.
REQ-024 SHALL compute all index comparisons at full SEW width (no truncation before range test).

Reset
REQ-025 SHALL, on rst_n low at any time, asynchronously force IDLE, in_ready=1, out_valid=0, err=0, vd_bus=0.
REQ-026 SHALL discard any in-flight operation on reset; no partial result is ever presented.

Configuration
REQ-027 SHALL, with VRGATHER_MASK_EN defined, add inputs vm (W/8 bits, bit i = element i mask) and vd_old (W), both captured with operands.
REQ-028 SHALL, with VRGATHER_MASK_EN defined, set active element i with vm[i]=0 to vd_old[i]; tail (i>=E) stays 0.
REQ-029 SHALL, without VRGATHER_MASK_EN, omit vm and vd_old ports; all active elements gathered.

Verification (VLEN_BITS=128, LMUL=4, LANES=8)
REQ-030 SHALL test sew=10, vl=16, vs1=[15,14..0], vs2[j]=j+100 -> vd[i]=115-i, out_valid 3 cycles after accept (2 RUN).
REQ-031 SHALL test sew=00, vl=64, vs1[i]=64 for all i, vs2 random -> vd all zeros, err=0.
REQ-032 SHALL test sew=01, vl=5, vs1[i]=0, vs2[0]=16'hBEEF -> vd[0..4]=BEEF, vd[5..31]=0, 1 RUN cycle.
REQ-033 SHALL test sew=11 and separately vl=0 -> out_valid next cycle, vd=0, err=1 only for sew=11.
REQ-034 SHALL test out_ready held low 5 cycles then high -> vd stable, in_ready low throughout, then high one cycle after handshake.
REQ-035 SHALL test rst_n pulsed low mid-RUN -> out_valid=0, vd_bus=0 immediately; next operation correct.
